// File: rtl/uart_pkg.sv
// Shared UART frame constants and receiver/transmitter state encoding.
// Frames are 8N1; the default bit period assumes a 32 MHz clock at 115200 baud.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 278;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial input pin plus received-byte strobe bundle of the UART receiver.
// master = receiver side, slave = pin driver / byte consumer side.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    output data,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data,
    input  data_valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser for asynchronous inputs; 2-cycle latency.
// No flow control; the reset value is chosen per use (idle level of the pin).
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle data_valid / frame_err strobes.
// data_valid follows the rx falling edge by 3 + HALF_BIT + 9*CLKS_PER_BIT cycles; no backpressure.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      // A start bit that is high again at its centre is treated as line noise.
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      // Deciding at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
      STOP: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      // Wait out a held-low line so it is not decoded as a stream of 0x00 bytes.
      BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: frame table plus reset, glitch, break and mid-frame reset sequences.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         dv_cnt      = 0;
  int         fe_cnt      = 0;
  int         both_err    = 0;
  int         busy_dv_err = 0;
  int         dv_cyc      = 0;
  int         start_cyc   = 0;
  logic [7:0] last_data   = 8'h00;

  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_cnt    = dv_cnt + 1;
      last_data = bus.data;
      dv_cyc    = cyc;
      if (bus.busy) busy_dv_err = busy_dv_err + 1;
    end
    if (bus.frame_err) fe_cnt = fe_cnt + 1;
    if (bus.data_valid && bus.frame_err) both_err = both_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop_bit;
    tick(CPB);
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_bit;
    int         gap_bits;
    int         exp_dv;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dv0, fe0, lat;
    bit seen_busy;

    vecs[0] = '{byte_v: 8'hA5, stop_bit: 1'b1, gap_bits: 2, exp_dv: 1, exp_fe: 0, exp_data: 8'hA5};
    vecs[1] = '{byte_v: 8'h55, stop_bit: 1'b1, gap_bits: 0, exp_dv: 1, exp_fe: 0, exp_data: 8'h55};
    vecs[2] = '{byte_v: 8'h0F, stop_bit: 1'b1, gap_bits: 2, exp_dv: 1, exp_fe: 0, exp_data: 8'h0F};
    vecs[3] = '{byte_v: 8'h3C, stop_bit: 1'b0, gap_bits: 0, exp_dv: 0, exp_fe: 1, exp_data: 8'h0F};

    // Reset with a toggling line: every output must stay at its reset value.
    bus.rx = 1'b1;
    rst    = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      bus.rx = ~bus.rx;
      tick(1);
      check($sformatf("rst%0d_data", i), 32'(bus.data), 32'h00);
      check($sformatf("rst%0d_dv", i), 32'(bus.data_valid), 32'h0);
      check($sformatf("rst%0d_fe", i), 32'(bus.frame_err), 32'h0);
      check($sformatf("rst%0d_busy", i), 32'(bus.busy), 32'h0);
    end
    bus.rx = 1'b1;
    rst    = 1'b0;
    tick(5);
    check("idle_dv_cnt", 32'(dv_cnt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].byte_v, vecs[i].stop_bit);
      if (vecs[i].gap_bits > 0) begin
        bus.rx = 1'b1;
        tick(vecs[i].gap_bits * CPB);
      end
      check($sformatf("vec%0d_dv_pulses", i), 32'(dv_cnt - dv0), 32'(vecs[i].exp_dv));
      check($sformatf("vec%0d_fe_pulses", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_data", i), 32'(bus.data), 32'(vecs[i].exp_data));
      if (vecs[i].exp_dv == 1) begin
        check($sformatf("vec%0d_data_at_strobe", i), 32'(last_data), 32'(vecs[i].exp_data));
        lat = dv_cyc - start_cyc;
        n_checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          n_fail++;
          $display("FAIL vec%0d_latency actual=%0d required=%0d+-1", i, lat, LAT);
        end
      end
    end

    // Line still held low after the bad stop bit: 50 bit times of break.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    tick(50 * CPB);
    check("break_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("break_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("break_busy", 32'(bus.busy), 32'd1);
    check("break_data_held", 32'(bus.data), 32'h0F);
    bus.rx = 1'b1;
    tick(4);
    check("break_release_busy", 32'(bus.busy), 32'd0);
    dv0 = dv_cnt;
    send_frame(8'h81, 1'b1);
    bus.rx = 1'b1;
    tick(2 * CPB);
    check("after_break_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("after_break_data", 32'(bus.data), 32'h81);

    // Short low glitch: busy must blip and the frame must be abandoned silently.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    seen_busy = 1'b0;
    bus.rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus.busy) seen_busy = 1'b1;
    end
    bus.rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen_busy), 32'd1);
    check("glitch_busy_end", 32'(bus.busy), 32'd0);
    check("glitch_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_data_held", 32'(bus.data), 32'h81);

    // Reset in the middle of data bit 4 of 0xFF.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    bus.rx = 1'b0;
    tick(CPB);
    bus.rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_data", 32'(bus.data), 32'h00);
    tick(2);
    rst = 1'b0;
    tick(6 * CPB);
    check("midrst_dv_pulses", 32'(dv_cnt - dv0), 32'd0);
    check("midrst_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
    dv0 = dv_cnt;
    send_frame(8'h12, 1'b1);
    bus.rx = 1'b1;
    tick(2 * CPB);
    check("post_rst_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
    check("post_rst_data", 32'(bus.data), 32'h12);
    check("post_rst_data_at_strobe", 32'(last_data), 32'h12);

    check("strobes_never_both", 32'(both_err), 32'd0);
    check("busy_low_on_strobe", 32'(busy_dv_err), 32'd0);
    check("total_dv_pulses", 32'(dv_cnt), 32'd5);
    check("total_fe_pulses", 32'(fe_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
